// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// The helpers take a fixed 32-bit argument so that any WIDTH up to 32 can reuse them through truncation.
package div_pkg;

   typedef enum logic [1:0] {IDLE, RUN, FINISH} div_state_e;

   // Iteration counter width; it must hold WIDTH-1, with at least one bit.
   function automatic int cnt_width(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

   function automatic logic [31:0] neg_val(input logic [31:0] x);
      return ~x + 32'd1;
   endfunction

   // The sign bit sits at position width-1; upper bits are ignored by the caller's truncation.
   function automatic logic [31:0] abs_val(input logic [31:0] x, input int width);
      return ((x & (32'd1 << (width - 1))) != 32'd0) ? neg_val(x) : x;
   endfunction

endpackage

// File: rtl/divisor_secuencial_param.sv
// Multi-cycle restoring divider with a start/busy/done handshake and divide-by-zero reporting.
// Signed mode divides magnitudes, then fixes the signs when the result is written.
module divisor_secuencial_param
   import div_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int SIGNED_DIV = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CNT_W = cnt_width(WIDTH);

   div_state_e       state, state_nx;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] rem_r, quo_r, dvs_r, raw_a;
   logic             sign_a, sign_b, dz_r;
   logic [WIDTH:0]   trial, diff;
   logic [WIDTH-1:0] q_fix, r_fix;

   // quo_r starts as the dividend magnitude and fills with quotient bits as it shifts out.
   assign trial = {rem_r, quo_r[WIDTH-1]};
   assign diff  = trial - {1'b0, dvs_r};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      busy     = (state != IDLE);
      case (state)
         IDLE:    if (start) state_nx = (divisor == '0) ? FINISH : RUN;
         RUN:     if (cnt == '0) state_nx = FINISH;
         FINISH:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Quotient is negative when operand signs differ; remainder follows the dividend's sign.
   always_comb begin
      q_fix = quo_r;
      r_fix = rem_r;
      if (SIGNED_DIV != 0) begin
         if (sign_a ^ sign_b) q_fix = WIDTH'(neg_val(32'(quo_r)));
         if (sign_a)          r_fix = WIDTH'(neg_val(32'(rem_r)));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt         <= '0;
         rem_r       <= '0;
         quo_r       <= '0;
         dvs_r       <= '0;
         raw_a       <= '0;
         sign_a      <= 1'b0;
         sign_b      <= 1'b0;
         dz_r        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  raw_a  <= dividend;
                  dz_r   <= (divisor == '0);
                  sign_a <= (SIGNED_DIV != 0) && dividend[WIDTH-1];
                  sign_b <= (SIGNED_DIV != 0) && divisor[WIDTH-1];
                  quo_r  <= (SIGNED_DIV != 0) ? WIDTH'(abs_val(32'(dividend), WIDTH)) : dividend;
                  dvs_r  <= (SIGNED_DIV != 0) ? WIDTH'(abs_val(32'(divisor), WIDTH)) : divisor;
                  rem_r  <= '0;
                  cnt    <= CNT_W'(WIDTH - 1);
               end
            end
            RUN: begin
               if (!diff[WIDTH]) begin
                  rem_r <= diff[WIDTH-1:0];
                  quo_r <= {quo_r[WIDTH-2:0], 1'b1};
               end else begin
                  rem_r <= trial[WIDTH-1:0];
                  quo_r <= {quo_r[WIDTH-2:0], 1'b0};
               end
               if (cnt != '0) cnt <= cnt - 1'b1;
            end
            FINISH: begin
               done        <= 1'b1;
               div_by_zero <= dz_r;
               quotient    <= dz_r ? '1 : q_fix;
               remainder   <= dz_r ? raw_a : r_fix;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_divisor_secuencial_param.sv
// Bench for the sequential divider: unsigned and signed 8-bit instances plus an unsigned 16-bit one,
// checked against plain-arithmetic expectations for results, latency, busy length and handshake rules.
module tb_divisor_secuencial_param;

   localparam int MAX_WAIT = 100;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        st0, st1, st2;
   logic [7:0]  a0, b0, a1, b1;
   logic [15:0] a2, b2;
   logic        bz0, bz1, bz2, dn0, dn1, dn2, dz0, dz1, dz2;
   logic [7:0]  q0, r0, q1, r1;
   logic [15:0] q2, r2;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] last_q [3];

   divisor_secuencial_param #(.WIDTH(8), .SIGNED_DIV(0)) dut_u8 (
      .clk(clk), .rst(rst), .start(st0), .dividend(a0), .divisor(b0),
      .busy(bz0), .done(dn0), .quotient(q0), .remainder(r0), .div_by_zero(dz0));

   divisor_secuencial_param #(.WIDTH(8), .SIGNED_DIV(1)) dut_s8 (
      .clk(clk), .rst(rst), .start(st1), .dividend(a1), .divisor(b1),
      .busy(bz1), .done(dn1), .quotient(q1), .remainder(r1), .div_by_zero(dz1));

   divisor_secuencial_param #(.WIDTH(16), .SIGNED_DIV(0)) dut_u16 (
      .clk(clk), .rst(rst), .start(st2), .dividend(a2), .divisor(b2),
      .busy(bz2), .done(dn2), .quotient(q2), .remainder(r2), .div_by_zero(dz2));

   function automatic logic get_busy(input int idx);
      case (idx)
         0:       return bz0;
         1:       return bz1;
         default: return bz2;
      endcase
   endfunction

   function automatic logic get_done(input int idx);
      case (idx)
         0:       return dn0;
         1:       return dn1;
         default: return dn2;
      endcase
   endfunction

   function automatic logic get_dz(input int idx);
      case (idx)
         0:       return dz0;
         1:       return dz1;
         default: return dz2;
      endcase
   endfunction

   function automatic logic [15:0] get_q(input int idx);
      case (idx)
         0:       return {8'h00, q0};
         1:       return {8'h00, q1};
         default: return q2;
      endcase
   endfunction

   function automatic logic [15:0] get_r(input int idx);
      case (idx)
         0:       return {8'h00, r0};
         1:       return {8'h00, r1};
         default: return r2;
      endcase
   endfunction

   task automatic set_in(input int idx, input logic s, input logic [15:0] a, input logic [15:0] b);
      case (idx)
         0:       begin st0 = s; a0 = a[7:0]; b0 = b[7:0]; end
         1:       begin st1 = s; a1 = a[7:0]; b1 = b[7:0]; end
         default: begin st2 = s; a2 = a;      b2 = b;      end
      endcase
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Reference: integer division semantics, truncated to the instance width.
   task automatic model(input int idx, input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] eq, output logic [15:0] er, output logic edz, output int elat);
      int w, sa, sb;
      logic [15:0] mask;
      w    = (idx == 2) ? 16 : 8;
      mask = (idx == 2) ? 16'hFFFF : 16'h00FF;
      if ((a & mask) === a && (b & mask) == 16'h0000) begin
         eq = mask; er = a; edz = 1'b1; elat = 1;
      end else begin
         edz  = 1'b0;
         elat = w + 1;
         if (idx == 1) begin
            sa = int'($signed(a[7:0]));
            sb = int'($signed(b[7:0]));
            eq = 16'(sa / sb) & mask;
            er = 16'(sa % sb) & mask;
         end else begin
            eq = (a / b) & mask;
            er = (a % b) & mask;
         end
      end
   endtask

   // Accept edge is the first rising edge with start high; operands are scrambled right after it.
   task automatic applyStimulus(input int idx, input logic [15:0] a, input logic [15:0] b,
                                output int lat, output int busy_cnt);
      @(negedge clk);
      set_in(idx, 1'b1, a, b);
      @(posedge clk);
      #1;
      set_in(idx, 1'b0, 16'($urandom), 16'($urandom));
      lat      = 0;
      busy_cnt = 0;
      while (!get_done(idx) && lat < MAX_WAIT) begin
         if (get_busy(idx)) busy_cnt++;
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic run_op(input int idx, input logic [15:0] a, input logic [15:0] b, input string tag);
      logic [15:0] eq, er;
      logic        edz;
      int          elat, lat, bcnt;
      model(idx, a, b, eq, er, edz, elat);
      applyStimulus(idx, a, b, lat, bcnt);
      checkOutput({tag, " latency"}, lat, elat);
      checkOutput({tag, " busy cycles"}, bcnt, elat);
      checkOutput({tag, " busy at done"}, get_busy(idx), 0);
      checkOutput({tag, " quotient"}, get_q(idx), eq);
      checkOutput({tag, " remainder"}, get_r(idx), er);
      checkOutput({tag, " div_by_zero"}, get_dz(idx), edz);
      @(posedge clk);
      #1;
      checkOutput({tag, " done width"}, get_done(idx), 0);
      last_q[idx] = eq;
   endtask

   initial begin
      int n, n_done, idx;
      logic [15:0] ra, rb;

      rst = 1'b1;
      for (int i = 0; i < 3; i++) set_in(i, 1'b0, 16'h0, 16'h0);
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("reset busy%0d", i), get_busy(i), 0);
         checkOutput($sformatf("reset done%0d", i), get_done(i), 0);
         checkOutput($sformatf("reset q%0d", i), get_q(i), 0);
         checkOutput($sformatf("reset r%0d", i), get_r(i), 0);
         checkOutput($sformatf("reset dz%0d", i), get_dz(i), 0);
      end
      @(negedge clk);
      rst = 1'b0;

      $display("[TB] directed operations");
      run_op(0, 16'd45, 16'd12, "u 45/12");
      run_op(0, 16'h002D, 16'h0000, "u div0");
      run_op(1, 16'h00D3, 16'h000C, "s -45/12");
      run_op(1, 16'h002D, 16'h00F4, "s 45/-12");
      run_op(1, 16'h0080, 16'h00FF, "s -128/-1");
      run_op(1, 16'h0080, 16'h0000, "s div0");

      // A start pulse three cycles into a run must be dropped without disturbing it.
      $display("[TB] start while busy");
      @(negedge clk);
      set_in(0, 1'b1, 16'd100, 16'd7);
      @(posedge clk);
      #1;
      set_in(0, 1'b0, 16'h0, 16'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      set_in(0, 1'b1, 16'd200, 16'd7);
      @(posedge clk);
      #1;
      set_in(0, 1'b0, 16'h0, 16'h0);
      checkOutput("held q during run", get_q(0), last_q[0]);
      n_done = 0;
      for (int i = 0; i < 30; i++) begin
         if (dn0) n_done++;
         @(posedge clk);
         #1;
      end
      checkOutput("busy start done count", n_done, 1);
      checkOutput("busy start quotient", q0, 14);
      checkOutput("busy start remainder", r0, 2);

      $display("[TB] reset during run");
      @(negedge clk);
      set_in(0, 1'b1, 16'd100, 16'd7);
      @(posedge clk);
      #1;
      set_in(0, 1'b0, 16'h0, 16'h0);
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("abort busy", bz0, 0);
      checkOutput("abort done", dn0, 0);
      checkOutput("abort q", q0, 0);
      checkOutput("abort r", r0, 0);
      checkOutput("abort dz", dz0, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      n_done = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk);
         #1;
         if (dn0) n_done++;
      end
      checkOutput("abort no done", n_done, 0);
      run_op(0, 16'd9, 16'd3, "u 9/3 after reset");

      $display("[TB] random operations");
      for (int i = 0; i < 24; i++) begin
         idx = i % 2;
         ra  = 16'($urandom_range(0, 255));
         rb  = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom_range(0, 255));
         run_op(idx, ra, rb, $sformatf("rand%0d %0h/%0h", i, ra, rb));
      end

      $display("[TB] 16-bit operations");
      run_op(2, 16'hFFFF, 16'h0001, "u16 65535/1");
      run_op(2, 16'd50000, 16'd0, "u16 div0");
      @(negedge clk);
      set_in(2, 1'b1, 16'hFFFF, 16'h0001);
      n = 0;
      while (!dn2 && n < MAX_WAIT) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("b2b first done", dn2, 1);
      for (int p = 0; p < 2; p++) begin
         n = 0;
         do begin
            @(posedge clk);
            #1;
            n++;
         end while (!dn2 && n < MAX_WAIT);
         checkOutput($sformatf("b2b period %0d", p), n, 18);
         checkOutput($sformatf("b2b q %0d", p), q2, 16'hFFFF);
         checkOutput($sformatf("b2b r %0d", p), r2, 16'h0000);
      end
      @(negedge clk);
      set_in(2, 1'b0, 16'h0, 16'h0);
      repeat (25) @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
